// File: rtl/cache_ctrl_nway_pkg.sv
// Shared types and width helpers for the N-way cache controller.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE,
    REFILL_WAIT
  } ctrl_state_t;

  function automatic int way_idx_w(int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic int plru_w(int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/cache_ctrl_nway_plru.sv
// Per-set tree-PLRU bit store: combinational victim walk and access update.
module plru_tree import cache_pkg::*; #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(SETS)-1:0]      rd_set,
  output logic [way_idx_w(WAYS)-1:0]   victim,
  input  logic [$clog2(SETS)-1:0]      upd_set,
  input  logic [way_idx_w(WAYS)-1:0]   upd_way,
  input  logic                         upd_en
);

  localparam int WAY_IDX_W = way_idx_w(WAYS);
  localparam int PLRU_W    = plru_w(WAYS);
  localparam int LEVELS    = $clog2(WAYS);

  logic [PLRU_W-1:0] bits [SETS];
  logic [PLRU_W-1:0] rd_bits;
  logic [PLRU_W-1:0] upd_bits;
  logic [PLRU_W-1:0] upd_next;
  int unsigned       rd_node;
  int unsigned       upd_node;
  logic              rd_b;
  logic              upd_b;

  assign rd_bits  = bits[rd_set];
  assign upd_bits = bits[upd_set];

  // Heap-ordered nodes: children of n are 2n+1 (lower half) and 2n+2 (upper half).
  always_comb begin
    victim  = '0;
    rd_node = 0;
    rd_b    = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      rd_b    = |((rd_bits >> rd_node) & PLRU_W'(1));
      victim  = victim | (WAY_IDX_W'(rd_b) << (LEVELS - 1 - l));
      rd_node = 2 * rd_node + (rd_b ? 2 : 1);
    end
  end

  always_comb begin
    upd_next = upd_bits;
    upd_node = 0;
    upd_b    = 1'b0;
    for (int unsigned l = 0; l < LEVELS; l++) begin
      upd_b    = |((upd_way >> (LEVELS - 1 - l)) & WAY_IDX_W'(1));
      upd_next = (upd_next & ~(PLRU_W'(1) << upd_node)) | (PLRU_W'(!upd_b) << upd_node);
      upd_node = 2 * upd_node + (upd_b ? 2 : 1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) bits[s] <= '0;
    end else if (upd_en) begin
      bits[upd_set] <= upd_next;
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way write-back cache controller with tree-PLRU, invalid-first victim choice.
// Optional CACHE_CTRL_FAST_HIT_EN keeps COMPARE on a hit when another request is pending.
module cache_ctrl_nway import cache_pkg::*; #(
  parameter int WAYS = 4,
  parameter int SETS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                ufp_rmask,
  input  logic [3:0]                ufp_wmask,
  input  logic [$clog2(SETS)-1:0]   set_idx,
  input  logic [WAYS-1:0]           way_hit,
  input  logic [WAYS-1:0]           way_valid,
  input  logic [WAYS-1:0]           way_dirty,
  input  logic                      dfp_resp,
  output logic                      ufp_resp,
  output logic                      dfp_read,
  output logic                      dfp_write,
  output logic [WAYS-1:0]           data_we,
  output logic                      data_src,
  output logic [WAYS-1:0]           tag_we,
  output logic [WAYS-1:0]           valid_we,
  output logic [WAYS-1:0]           dirty_we,
  output logic                      dirty_in,
  output logic                      addr_sel,
  output logic [$clog2(WAYS)-1:0]   victim_way,
  output logic                      busy
);

  localparam int WAY_IDX_W = way_idx_w(WAYS);

  ctrl_state_t          state, state_next;
  logic [WAY_IDX_W-1:0] victim_q, victim_sel, hit_idx, inv_idx, plru_victim;
  logic [WAYS-1:0]      hit_oh, victim_oh;
  logic                 hit, any_inv, req, is_write, plru_upd;

  assign req       = (|ufp_rmask) || (|ufp_wmask);
  assign is_write  = |ufp_wmask;
  assign hit_oh    = WAYS'(1) << hit_idx;
  assign victim_oh = WAYS'(1) << victim_q;

  // Lowest-index priority resolves both multi-hit and the first invalid way.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    any_inv = 1'b0;
    inv_idx = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (way_hit[i] && !hit) begin
        hit     = 1'b1;
        hit_idx = WAY_IDX_W'(i);
      end
      if (!way_valid[i] && !any_inv) begin
        any_inv = 1'b1;
        inv_idx = WAY_IDX_W'(i);
      end
    end
    victim_sel = any_inv ? inv_idx : plru_victim;
  end

  plru_tree #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) u_plru (
    .clk     (clk),
    .rst     (rst),
    .rd_set  (set_idx),
    .victim  (plru_victim),
    .upd_set (set_idx),
    .upd_way (hit_idx),
    .upd_en  (plru_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      victim_q <= '0;
    end else begin
      state <= state_next;
      if (state == COMPARE && !hit) victim_q <= victim_sel;
    end
  end

  always_comb begin
    state_next = state;
    ufp_resp   = 1'b0;
    dfp_read   = 1'b0;
    dfp_write  = 1'b0;
    data_we    = '0;
    data_src   = 1'b0;
    tag_we     = '0;
    valid_we   = '0;
    dirty_we   = '0;
    dirty_in   = 1'b0;
    addr_sel   = 1'b0;
    plru_upd   = 1'b0;
    unique case (state)
      IDLE: if (req) state_next = COMPARE;
      COMPARE: begin
        if (hit) begin
          ufp_resp = 1'b1;
          plru_upd = 1'b1;
          if (is_write) begin
            data_we  = hit_oh;
            dirty_we = hit_oh;
            dirty_in = 1'b1;
          end
`ifdef CACHE_CTRL_FAST_HIT_EN
          state_next = req ? COMPARE : IDLE;
`else
          state_next = IDLE;
`endif
        end else begin
          state_next = (way_valid[victim_sel] && way_dirty[victim_sel]) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        dfp_write = 1'b1;
        addr_sel  = 1'b1;
        if (dfp_resp) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        dfp_read = 1'b1;
        if (dfp_resp) begin
          data_we    = victim_oh;
          tag_we     = victim_oh;
          valid_we   = victim_oh;
          dirty_we   = victim_oh;
          data_src   = 1'b1;
          state_next = REFILL_WAIT;
        end
      end
      REFILL_WAIT: state_next = COMPARE;
      default:     state_next = IDLE;
    endcase
  end

  assign victim_way = victim_q;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed table-driven bench for cache_ctrl_nway (WAYS=4, SETS=16).
module tb_cache_ctrl_nway;

  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam logic [3:0] ALL = 4'hF;

  logic       clk, rst;
  logic [3:0] ufp_rmask, ufp_wmask, set_idx;
  logic [3:0] way_hit, way_valid, way_dirty;
  logic       dfp_resp;
  logic       ufp_resp, dfp_read, dfp_write, data_src, dirty_in, addr_sel, busy;
  logic [1:0] victim_way;
  logic [3:0] data_we, tag_we, valid_we, dirty_we;

  cache_ctrl_nway #(
    .WAYS (WAYS),
    .SETS (SETS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ufp_rmask  (ufp_rmask),
    .ufp_wmask  (ufp_wmask),
    .set_idx    (set_idx),
    .way_hit    (way_hit),
    .way_valid  (way_valid),
    .way_dirty  (way_dirty),
    .dfp_resp   (dfp_resp),
    .ufp_resp   (ufp_resp),
    .dfp_read   (dfp_read),
    .dfp_write  (dfp_write),
    .data_we    (data_we),
    .data_src   (data_src),
    .tag_we     (tag_we),
    .valid_we   (valid_we),
    .dirty_we   (dirty_we),
    .dirty_in   (dirty_in),
    .addr_sel   (addr_sel),
    .victim_way (victim_way),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rmask, wmask, set, hit, valid, dirty;
    logic       resp;
  } in_t;

  typedef struct packed {
    logic       ufp_resp, dfp_read, dfp_write, data_src, dirty_in, addr_sel, busy;
    logic [1:0] victim;
    logic [3:0] data_we, tag_we, valid_we, dirty_we;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;
  int   nresp  = 0;

  function automatic in_t mk_in(logic [3:0] rm, logic [3:0] wm, logic [3:0] set,
                                logic [3:0] hit, logic [3:0] valid, logic [3:0] dirty,
                                logic resp);
    return in_t'{rm, wm, set, hit, valid, dirty, resp};
  endfunction

  function automatic out_t o_base(logic [1:0] vic, logic bsy);
    out_t o = '0;
    o.victim = vic;
    o.busy   = bsy;
    return o;
  endfunction

  function automatic out_t o_idle(logic [1:0] vic);
    return o_base(vic, 1'b0);
  endfunction

  function automatic out_t o_busy(logic [1:0] vic);
    return o_base(vic, 1'b1);
  endfunction

  function automatic out_t o_resp(logic [1:0] vic, logic [3:0] dwe);
    out_t o = o_base(vic, 1'b1);
    o.ufp_resp = 1'b1;
    o.data_we  = dwe;
    o.dirty_we = dwe;
    o.dirty_in = |dwe;
    return o;
  endfunction

  function automatic out_t o_rd(logic [1:0] vic);
    out_t o = o_base(vic, 1'b1);
    o.dfp_read = 1'b1;
    return o;
  endfunction

  function automatic out_t o_wb(logic [1:0] vic);
    out_t o = o_base(vic, 1'b1);
    o.dfp_write = 1'b1;
    o.addr_sel  = 1'b1;
    return o;
  endfunction

  function automatic out_t o_fill(logic [1:0] vic);
    out_t       o  = o_rd(vic);
    logic [3:0] oh = 4'b0001 << vic;
    o.data_src = 1'b1;
    o.data_we  = oh;
    o.tag_we   = oh;
    o.valid_we = oh;
    o.dirty_we = oh;
    return o;
  endfunction

  function automatic out_t act();
    out_t a;
    a.ufp_resp  = ufp_resp;
    a.dfp_read  = dfp_read;
    a.dfp_write = dfp_write;
    a.data_src  = data_src;
    a.dirty_in  = dirty_in;
    a.addr_sel  = addr_sel;
    a.busy      = busy;
    a.victim    = victim_way;
    a.data_we   = data_we;
    a.tag_we    = tag_we;
    a.valid_we  = valid_we;
    a.dirty_we  = dirty_we;
    return a;
  endfunction

  task automatic drive(input in_t v);
    ufp_rmask = v.rmask;
    ufp_wmask = v.wmask;
    set_idx   = v.set;
    way_hit   = v.hit;
    way_valid = v.valid;
    way_dirty = v.dirty;
    dfp_resp  = v.resp;
  endtask

  task automatic check(input string name, input out_t e);
    out_t a;
    a = act();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic cyc(input string name, input in_t v, input out_t e);
    @(negedge clk);
    drive(v);
    #1;
    check(name, e);
  endtask

  task automatic add(input string n, input in_t v, input out_t e);
    vec_t t;
    t.name = n;
    t.stim = v;
    t.exp  = e;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    in_t z, cold, wr, rw, m, mr, d, dr, c7;
    z    = mk_in(4'h0, 4'h0, 4'd3, 4'h0, ALL, 4'h0, 1'b0);
    cold = mk_in(ALL, 4'h0, 4'd3, 4'h0, 4'h0, 4'h0, 1'b0);
    wr   = mk_in(4'h0, 4'h3, 4'd3, 4'b0100, ALL, 4'h0, 1'b0);
    rw   = mk_in(ALL, 4'h1, 4'd3, 4'b0110, ALL, 4'h0, 1'b0);
    m    = mk_in(ALL, 4'h0, 4'd5, 4'h0, ALL, 4'h0, 1'b0);
    mr   = mk_in(ALL, 4'h0, 4'd5, 4'h0, ALL, 4'h0, 1'b1);
    d    = mk_in(ALL, 4'h0, 4'd5, 4'h0, ALL, ALL, 1'b0);
    dr   = mk_in(ALL, 4'h0, 4'd5, 4'h0, ALL, ALL, 1'b1);
    c7   = mk_in(ALL, 4'h0, 4'd7, 4'h0, 4'b0011, 4'h0, 1'b0);

    // Cold read miss in set 3, dfp_resp three cycles into ALLOCATE.
    add("cold_idle",   cold, o_idle(2'd0));
    add("cold_cmp",    cold, o_busy(2'd0));
    add("cold_alloc",  cold, o_rd(2'd0));
    add("cold_alloc",  cold, o_rd(2'd0));
    add("cold_fill",   mk_in(ALL, 4'h0, 4'd3, 4'h0, 4'h0, 4'h0, 1'b1), o_fill(2'd0));
    add("cold_refill", cold, o_busy(2'd0));
    add("cold_hit",    mk_in(ALL, 4'h0, 4'd3, 4'b0001, 4'b0001, 4'h0, 1'b0), o_resp(2'd0, 4'h0));
    add("cold_done",   z, o_idle(2'd0));
    add("wr_idle",     wr, o_idle(2'd0));
    add("wr_hit",      wr, o_resp(2'd0, 4'b0100));
    add("wr_done",     z, o_idle(2'd0));
    add("rw_idle",     rw, o_idle(2'd0));
    add("rw_hit",      rw, o_resp(2'd0, 4'b0010));
    add("rw_done",     z, o_idle(2'd0));
    add("ign_resp",    mk_in(4'h0, 4'h0, 4'd3, 4'h0, ALL, 4'h0, 1'b1), o_idle(2'd0));
    add("ign_hold",    z, o_idle(2'd0));
    for (int w = 0; w < 4; w++) begin
      add("plru_idle", mk_in(ALL, 4'h0, 4'd5, 4'(1 << w), ALL, 4'h0, 1'b0), o_idle(2'd0));
      add("plru_hit",  mk_in(ALL, 4'h0, 4'd5, 4'(1 << w), ALL, 4'h0, 1'b0), o_resp(2'd0, 4'h0));
    end
    add("m1_idle",     m,  o_idle(2'd0));
    add("m1_cmp",      m,  o_busy(2'd0));
    add("m1_alloc",    m,  o_rd(2'd0));
    add("m1_fill",     mr, o_fill(2'd0));
    add("m1_refill",   m,  o_busy(2'd0));
    add("m1_hit",      mk_in(ALL, 4'h0, 4'd5, 4'b0001, ALL, 4'h0, 1'b0), o_resp(2'd0, 4'h0));
    add("h0_idle",     mk_in(ALL, 4'h0, 4'd5, 4'b0001, ALL, 4'h0, 1'b0), o_idle(2'd0));
    add("h0_hit",      mk_in(ALL, 4'h0, 4'd5, 4'b0001, ALL, 4'h0, 1'b0), o_resp(2'd0, 4'h0));
    add("m2_idle",     m,  o_idle(2'd0));
    add("m2_cmp",      m,  o_busy(2'd0));
    add("m2_alloc",    m,  o_rd(2'd2));
    add("m2_fill",     mr, o_fill(2'd2));
    add("m2_refill",   m,  o_busy(2'd2));
    add("m2_hit",      mk_in(ALL, 4'h0, 4'd5, 4'b0100, ALL, 4'h0, 1'b0), o_resp(2'd2, 4'h0));
    add("dv_idle",     d,  o_idle(2'd2));
    add("dv_cmp",      d,  o_busy(2'd2));
    add("dv_wb",       d,  o_wb(2'd1));
    add("dv_wb",       d,  o_wb(2'd1));
    add("dv_wb_resp",  dr, o_wb(2'd1));
    add("dv_alloc",    d,  o_rd(2'd1));
    add("dv_fill",     dr, o_fill(2'd1));
    add("dv_refill",   d,  o_busy(2'd1));
    add("dv_hit",      mk_in(ALL, 4'h0, 4'd5, 4'b0010, ALL, 4'b1101, 1'b0), o_resp(2'd1, 4'h0));
    add("dv_done",     z,  o_idle(2'd1));

    rst = 1'b1;
    drive(mk_in(4'h0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    check("reset", o_idle(2'd0));
    rst = 1'b0;

    foreach (vecs[i]) cyc($sformatf("%s[%0d]", vecs[i].name, i), vecs[i].stim, vecs[i].exp);

    // Reset while ALLOCATE waits on dfp_resp; set 5 PLRU would otherwise pick way 3.
    cyc("ra_idle",  c7, o_idle(2'd1));
    cyc("ra_cmp",   c7, o_busy(2'd1));
    cyc("ra_alloc", c7, o_rd(2'd2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc("ra_after",  z,  o_idle(2'd0));
    cyc("pc_idle",   m,  o_idle(2'd0));
    cyc("pc_cmp",    m,  o_busy(2'd0));
    cyc("pc_alloc",  m,  o_rd(2'd0));
    cyc("pc_fill",   mr, o_fill(2'd0));
    cyc("pc_refill", m,  o_busy(2'd0));
    cyc("pc_hit",    mk_in(ALL, 4'h0, 4'd5, 4'b0001, ALL, 4'h0, 1'b0), o_resp(2'd0, 4'h0));
    cyc("pc_done",   z,  o_idle(2'd0));

    // Back-to-back read hits in set 6.
    for (int c = 0; c < 10; c++) begin
      logic on;
      logic exp_resp;
`ifdef CACHE_CTRL_FAST_HIT_EN
      on       = (c < 4);
      exp_resp = (c >= 1) && (c <= 4);
`else
      on       = (c < 8);
      exp_resp = (c % 2 == 1) && (c <= 7);
`endif
      @(negedge clk);
      drive(mk_in(on ? ALL : 4'h0, 4'h0, 4'd6, 4'(1 << (c % 4)), ALL, 4'h0, 1'b0));
      #1;
      checks++;
      if (ufp_resp !== exp_resp) begin
        errors++;
        $display("FAIL b2b_resp[%0d]: got %b expected %b", c, ufp_resp, exp_resp);
      end
      if (ufp_resp === 1'b1) nresp++;
    end
    checks++;
    if (nresp != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d expected 4", nresp);
    end
    cyc("b2b_end", z, o_idle(2'd0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_ctrl_nway.md
# cache_ctrl_nway

Parametrised N-way write-back cache controller with integrated per-set tree-PLRU replacement and invalid-first victim selection. Sits between the upstream (ufp) request port and the downstream (dfp) memory port. Drives one-hot per-way write enables into the tag, data, valid and dirty arrays of the cache datapath. It succeeds the fixed 4-way controller with its external PLRU and adds an optional back-to-back hit path.

## Interface
Parameters:
- WAYS, 4: associativity; power of two, 2..16.
- SETS, 16: number of sets; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- ufp_rmask  in  4  read byte mask; nonzero means a read request.
- ufp_wmask  in  4  write byte mask; nonzero means a write request. If both masks are nonzero, the request is a write.
- set_idx  in  $clog2(SETS)  set index of the current request; held stable by upstream until ufp_resp.
- way_hit  in  WAYS  one-hot tag-match AND valid for the indexed set.
- way_valid  in  WAYS  valid bits of the indexed set.
- way_dirty  in  WAYS  dirty bits of the indexed set.
- dfp_resp  in  1  downstream transfer complete.
- ufp_resp  out  1  request complete, single-cycle pulse.
- dfp_read  out  1  line refill request.
- dfp_write  out  1  line writeback request.
- data_we  out  WAYS  data array write enable, one-hot.
- data_src  out  1  data source: 0 = ufp write data (masked), 1 = dfp line.
- tag_we, valid_we, dirty_we  out  WAYS each  per-way array enables.
- dirty_in  out  1  dirty bit value to write.
- addr_sel  out  1  dfp address source: 0 = request tag, 1 = victim tag.
- victim_way  out  $clog2(WAYS)  latched victim index.
- busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, COMPARE, WRITEBACK, ALLOCATE, REFILL_WAIT.
- **IDLE**
  - Go to COMPARE if either mask is nonzero.
  - The datapath SRAM read happens in this cycle.
- **COMPARE, hit**
  - Pulse ufp_resp.
  - Update PLRU for the hit way at set_idx.
  - On a write: data_we and dirty_we go to the hit way, data_src=0, dirty_in=1.
  - Next state is IDLE, or see the macro in Configuration.
- **COMPARE, miss**
  - Latch victim_way: lowest-index way with way_valid=0; if all ways are valid, use the PLRU victim of set_idx.
  - If the victim is valid and dirty, go to WRITEBACK; otherwise go to ALLOCATE.
- **WRITEBACK**
  - dfp_write=1, addr_sel=1.
  - On dfp_resp, go to ALLOCATE.
- **ALLOCATE**
  - dfp_read=1, addr_sel=0.
  - In the dfp_resp cycle:
    - data_we, tag_we, valid_we and dirty_we all go to victim_way.
    - data_src=1, dirty_in=0.
    - Next state is REFILL_WAIT.
- **REFILL_WAIT**
  - One cycle for the array write and re-read, then COMPARE. COMPARE now hits and performs the PLRU update and any write merge.
- **Tree PLRU**
  - WAYS-1 bits per set; all zero at reset.
  - Node bit 0 means the victim lies in the lower-index subtree.
  - On access, every node on the path is set to point away from the accessed way.
- **Illegal and ignored inputs**
  - Multi-bit way_hit is illegal; the lowest set bit is used.
  - dfp_resp outside WRITEBACK and ALLOCATE is ignored.

## Timing
- **Reset**
  - State goes to IDLE and all PLRU bits clear.
  - All outputs are 0, including victim_way=0 and busy=0.
  - Reset mid-miss abandons the dfp transaction. dfp_read and dfp_write deassert on the cycle after the reset edge.
- **Latencies** (request first seen in IDLE at cycle 0):
  - Hit: ufp_resp in cycle 1.
  - Clean miss with dfp_resp at cycle k (k≥2): REFILL_WAIT at k+1, ufp_resp at k+2.
  - Dirty miss: add the WRITEBACK duration in front of ALLOCATE.
- **Downstream handshake**
  - dfp_read and dfp_write are held high continuously until dfp_resp; never both at once.
  - dfp_write drops in the cycle after its dfp_resp, when dfp_read rises.
- **Stability**
  - victim_way stays stable from COMPARE-miss until the next COMPARE.
  - The PLRU state is written only on a COMPARE hit.

## Configuration
- CACHE_CTRL_FAST_HIT_EN
  - **Defined:** on a COMPARE hit, the next state is COMPARE if either mask is nonzero in that cycle; otherwise IDLE. The datapath must index the SRAM with the next request's address in the ufp_resp cycle. This gives one hit per cycle.
  - **Undefined:** a hit always returns to IDLE, so the minimum spacing is 2 cycles per request.

## Structure
- **cache_pkg**
  - ctrl_state_t enum.
  - Localparams WAY_IDX_W=$clog2(WAYS) and PLRU_W=WAYS-1, as functions of the parameters.
- **Sub-module plru_tree**
  - Parametrised by WAYS and SETS.
  - Holds the per-set PLRU bit array with synchronous reset.
  - Combinational victim output for a read set.
  - Update port: set, way, enable.

## Test plan
- **Cold read** (WAYS=4, after reset, rmask=4'hF, set 3, way_valid=0):
  - Clean-miss path with victim_way=0.
  - dfp_read held until dfp_resp; valid_we=4'b0001 in the dfp_resp cycle.
  - ufp_resp 2 cycles later.
- **Write hit** (way_hit=4'b0100, wmask=4'h3):
  - ufp_resp in cycle 1.
  - data_we=4'b0100, dirty_we=4'b0100, dirty_in=1.
- **PLRU order** (all valid, all clean, set 5):
  - Hit ways 0,1,2,3 in turn, then miss: victim_way=0.
  - Hit 0, then miss: victim_way=2.
- **Dirty eviction** (way_valid=4'hF, way_dirty=4'hF):
  - dfp_write with addr_sel=1 until dfp_resp.
  - Then dfp_read with addr_sel=0; both never high together.
- **Reset during ALLOCATE** (before dfp_resp): next cycle state IDLE, dfp_read=0, busy=0, PLRU cleared.
- **Back-to-back hits**
  - With CACHE_CTRL_FAST_HIT_EN: 4 back-to-back hits give 4 ufp_resp in 4 consecutive cycles.
  - Without the macro: resp every other cycle.
